// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART receiver: 2-flop synchronizer, start/data/parity/stop FSM,
// registered data word with framing and parity error flags and a one-clk done strobe.
module uart_rx_oversample #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            framing_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            par_q, par_d;
  logic            sync1_q, sync2_q;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            rx_sync;

  // Mismatch between received data+parity and the expected parity sense.
  function automatic logic parity_mismatch(input logic [DBIT-1:0] data, input logic pbit);
    return (PARITY_EN != 0) && ((^data ^ pbit) != (PARITY_ODD != 0));
  endfunction

  assign rx_sync = sync2_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    par_d   = par_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        // Falling edge is taken immediately; a coincident tick is not counted.
        if (!rx_sync) begin
          state_d = START;
          s_d     = 5'd0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 5'd7) begin
            if (!rx_sync) begin
              state_d = DATA;
              s_d     = 5'd0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            shift_d = {rx_sync, shift_q[DBIT-1:1]};
            s_d     = 5'd0;
            if (n_q == NW'(DBIT - 1)) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            par_d   = rx_sync;
            s_d     = 5'd0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = shift_q;
            ferr_d  = ~rx_sync;
            perr_d  = parity_mismatch(shift_q, par_q);
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      s_q     <= 5'd0;
      n_q     <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign framing_err  = ferr_q;
  assign parity_err   = perr_q;
  assign busy         = (state_q != IDLE);

endmodule
